dual_issue_scheduler: RTL

//  Issue stage directly downstream of the instruction fetch buffer. Consumes instruction0/instruction1
//  and nothing_filled; decides each cycle whether to issue both, one or none of the pair into two

---
 rtl/sched_pkg.sv | 55 +++++
 rtl/sched_scoreboard.sv | 48 ++++
 rtl/dual_issue_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// sched_pkg
//   Shared decode definitions for the dual-issue scheduler: RV32I major
//   opcodes, the issue-class enum and a decode function that extracts the
//   register fields together with "actually used" flags. A flag is set only
//   when the field is architecturally read/written AND names a register
//   other than x0, so downstream hazard logic never has to special-case x0.
package sched_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_MEM,
        CLS_CTRL,
        CLS_SYS
    } issue_class_e;

    typedef struct packed {
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic         use_rd;
        logic         use_rs1;
        logic         use_rs2;
        issue_class_e cls;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic [6:0] opc;
        opc       = ins[6:0];
        d.rd      = ins[11:7];
        d.rs1     = ins[19:15];
        d.rs2     = ins[24:20];
        unique case (opc)
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: d.cls = CLS_ALU;
            OPC_LOAD, OPC_STORE:                   d.cls = CLS_MEM;
            OPC_BRANCH, OPC_JAL, OPC_JALR:         d.cls = CLS_CTRL;
            default:                               d.cls = CLS_SYS;
        endcase
        d.use_rs1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL) && (d.rs1 != 5'd0);
        d.use_rs2 = (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH) && (d.rs2 != 5'd0);
        d.use_rd  = !(opc == OPC_STORE || opc == OPC_BRANCH) && (d.rd != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/sched_scoreboard.sv
// sched_scoreboard
//   Tracks destination registers of issued loads that have not yet written
//   back.
//   i_clk      clock
//   i_rst      asynchronous reset, active high
//   i_set_en   a load to i_set_rd issues this cycle
//   i_set_rd   destination of the issuing load
//   i_clr_en   load writeback completes this cycle
//   i_clr_rd   destination of the completing load
//   o_pend_eff pending mask with this cycle's writeback already removed
import sched_pkg::*;

module sched_scoreboard #(
    parameter int NREGS = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_set_en,
    input  logic [4:0]       i_set_rd,
    input  logic             i_clr_en,
    input  logic [4:0]       i_clr_rd,
    output logic [NREGS-1:0] o_pend_eff
);

    localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_clr_mask;
    logic [NREGS-1:0] w_set_mask;

    assign w_clr_mask = i_clr_en ? (ONE << i_clr_rd) : '0;
    assign w_set_mask = i_set_en ? (ONE << i_set_rd) : '0;

    // Writeback bypass: a register completing this cycle is already free
    // for the hazard check.
    assign o_pend_eff = r_pending & ~w_clr_mask;

    // Set is OR-ed in after the clear so a same-register set+clear leaves it
    // pending; bit 0 is masked so x0 can never be pending.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (o_pend_eff | w_set_mask) & ~ONE;
        end
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
//   Issue stage behind the fetch buffer. Each cycle decides whether the
//   buffered pair issues dual, single (slot0 only) or not at all, and tells
//   the buffer how far to slide.
//   clk, n_rst             clock; async reset, active HIGH despite the name
//   instruction0/1         oldest / next buffered instruction, 0 = empty
//   nothing_filled         buffer empty
//   ex_ready               execute accepts a new pair this cycle
//   ld_wb_valid/ld_wb_rd   load writeback completing this cycle
//   freeze1                nothing issues, buffer holds
//   freeze2                slot1 held back solely by a pending load
//   dependency_on_ins2     only slot0 issues, buffer slides by 1
//   issue0/1_valid/instr   registered lane0 (any op) / lane1 (ALU only)
//   stall_cycles           saturating count of freeze1 cycles
import sched_pkg::*;

module dual_issue_scheduler #(
    parameter int XLEN        = 32,
    parameter int NREGS       = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [XLEN-1:0]        instruction0,
    input  logic [XLEN-1:0]        instruction1,
    input  logic                   nothing_filled,
    input  logic                   ex_ready,
    input  logic                   ld_wb_valid,
    input  logic [4:0]             ld_wb_rd,
    output logic                   freeze1,
    output logic                   freeze2,
    output logic                   dependency_on_ins2,
    output logic                   issue0_valid,
    output logic [XLEN-1:0]        issue0_instr,
    output logic                   issue1_valid,
    output logic [XLEN-1:0]        issue1_instr,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    dec_t             w_d0, w_d1;
    logic [NREGS-1:0] w_pend_eff;
    logic             w_hit0, w_hit1;
    logic             w_can0, w_raw, w_waw, w_blk_struct, w_blk1;
    logic             w_iss0, w_iss1, w_set_ld;

    assign w_d0 = decode(instruction0[31:0]);
    assign w_d1 = decode(instruction1[31:0]);

    function automatic logic pend_hit(input dec_t d, input logic [NREGS-1:0] p);
        return (d.use_rs1 && p[d.rs1]) || (d.use_rs2 && p[d.rs2]) || (d.use_rd && p[d.rd]);
    endfunction

    assign w_hit0 = pend_hit(w_d0, w_pend_eff);
    assign w_hit1 = pend_hit(w_d1, w_pend_eff);

    // An empty slot0 makes the whole pair empty, even if slot1 is non-zero.
    assign w_can0 = !nothing_filled && (instruction0 != '0) && ex_ready && !w_hit0;

    assign w_raw = w_d0.use_rd &&
                   ((w_d1.use_rs1 && (w_d1.rs1 == w_d0.rd)) ||
                    (w_d1.use_rs2 && (w_d1.rs2 == w_d0.rd)));
    assign w_waw = w_d0.use_rd && w_d1.use_rd && (w_d1.rd == w_d0.rd);

    // Everything that blocks slot1 other than the scoreboard; freeze2 is
    // raised only when the scoreboard is the sole reason.
    assign w_blk_struct = (instruction1 == '0) || (w_d1.cls != CLS_ALU) ||
                          (w_d0.cls == CLS_CTRL) || w_raw || w_waw;
    assign w_blk1 = w_blk_struct || w_hit1;

    always_comb begin
        freeze1            = 1'b1;
        freeze2            = 1'b0;
        dependency_on_ins2 = 1'b0;
        w_iss0             = 1'b0;
        w_iss1             = 1'b0;
        if (!n_rst && w_can0) begin
            freeze1 = 1'b0;
            w_iss0  = 1'b1;
            if (w_blk1) begin
                dependency_on_ins2 = 1'b1;
                freeze2            = !w_blk_struct;
            end else begin
                w_iss1 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            issue0_valid <= 1'b0;
            issue0_instr <= '0;
            issue1_valid <= 1'b0;
            issue1_instr <= '0;
        end else if (ex_ready) begin
            issue0_valid <= w_iss0;
            issue0_instr <= w_iss0 ? instruction0 : '0;
            issue1_valid <= w_iss1;
            issue1_instr <= w_iss1 ? instruction1 : '0;
        end
    end

    // Only lane0 can carry a load.
    assign w_set_ld = w_iss0 && (instruction0[6:0] == OPC_LOAD) && w_d0.use_rd;

    sched_scoreboard #(.NREGS(NREGS)) u_sb (
        .i_clk      (clk),
        .i_rst      (n_rst),
        .i_set_en   (w_set_ld),
        .i_set_rd   (w_d0.rd),
        .i_clr_en   (ld_wb_valid),
        .i_clr_rd   (ld_wb_rd),
        .o_pend_eff (w_pend_eff)
    );

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            stall_cycles <= '0;
        end else if (freeze1 && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule
